// File: rtl/execute_pipe_if.sv
// Handshake and data bundle between the decode stage, the execute stage and
// the memory stage; the execute stage sits on the slave side.
interface execute_pipe_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       icode;
   logic [3:0]       ifun;
   logic [WIDTH-1:0] valA;
   logic [WIDTH-1:0] valB;
   logic [WIDTH-1:0] valC;
   logic             set_cc_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] valE;
   logic             Cnd;
   logic [3:0]       out_icode;
   logic             out_err;
   logic [2:0]       cc_out;

   modport master (
      output in_valid, icode, ifun, valA, valB, valC, set_cc_en, out_ready,
      input  in_ready, out_valid, valE, Cnd, out_icode, out_err, cc_out
   );

   modport slave (
      input  in_valid, icode, ifun, valA, valB, valC, set_cc_en, out_ready,
      output in_ready, out_valid, valE, Cnd, out_icode, out_err, cc_out
   );
endinterface

// File: rtl/execute_pipe.sv
// Y86 execute stage: ALU operand select, ALU, condition codes and a single
// output register with valid/ready flow control.
module execute_pipe #(
   parameter int WIDTH = 64
) (
   input logic           clk,
   input logic           reset,
   execute_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alu_fn_e;

   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(WIDTH / 8);

   logic [WIDTH-1:0] alu_a, alu_b, alu_result, result_next;
   alu_fn_e          alu_fn;
   logic             op_illegal, err_next, cnd_next, cond_true;
   logic             zf, sf, of;
   logic             accept, cc_we;

   logic             out_valid_q, cnd_q, err_q;
   logic [WIDTH-1:0] val_e_q;
   logic [3:0]       icode_q;
   logic [2:0]       cc_q;            // {ZF, SF, OF}

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // NOTE: every always_comb output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      unique case (bus.icode)
         I_CMOV, I_OPQ:          alu_a = bus.valA;
         I_IRMOV, I_RMMOV, I_MRMOV: alu_a = bus.valC;
         I_CALL, I_PUSH:         alu_a = -STACK_STEP;
         I_RET, I_POP:           alu_a = STACK_STEP;
         default:                alu_a = '0;
      endcase
      unique case (bus.icode)
         I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = bus.valB;
         default:                alu_b = '0;
      endcase
   end

   assign op_illegal = (bus.icode == I_OPQ) && (bus.ifun[3:2] != 2'b00);
   assign alu_fn     = (bus.icode == I_OPQ) ? alu_fn_e'(bus.ifun[1:0]) : ALU_ADD;

   always_comb begin
      alu_result = '0;
      of         = 1'b0;
      unique case (alu_fn)
         ALU_ADD: begin
            alu_result = alu_b + alu_a;
            of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                 (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_result = alu_b - alu_a;
            of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                 (alu_result[WIDTH-1] != alu_b[WIDTH-1]);
         end
         ALU_AND: alu_result = alu_b & alu_a;
         ALU_XOR: alu_result = alu_b ^ alu_a;
         default: alu_result = '0;
      endcase
   end

   assign zf = (alu_result == '0);
   assign sf = alu_result[WIDTH-1];

   // Conditions read the CC as it stands before this instruction's own update.
   always_comb begin
      cond_true = 1'b0;
      case (bus.ifun)
         4'h0:    cond_true = 1'b1;
         4'h1:    cond_true = (cc_q[1] ^ cc_q[0]) | cc_q[2];
         4'h2:    cond_true = cc_q[1] ^ cc_q[0];
         4'h3:    cond_true = cc_q[2];
         4'h4:    cond_true = !cc_q[2];
         4'h5:    cond_true = !(cc_q[1] ^ cc_q[0]);
         4'h6:    cond_true = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
         default: cond_true = 1'b0;
      endcase
   end

   assign cnd_next    = ((bus.icode == I_CMOV) || (bus.icode == I_JXX)) && cond_true;
   assign err_next    = (bus.icode > I_POP) || op_illegal;
   // Faulting instructions report a zero result rather than a partial ALU value.
   assign result_next = err_next ? '0 : alu_result;
   assign cc_we       = accept && (bus.icode == I_OPQ) && !op_illegal && bus.set_cc_en;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         val_e_q     <= '0;
         cnd_q       <= 1'b0;
         icode_q     <= 4'h0;
         err_q       <= 1'b0;
         cc_q        <= 3'b100;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            val_e_q     <= result_next;
            cnd_q       <= cnd_next;
            icode_q     <= bus.icode;
            err_q       <= err_next;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (cc_we) begin
            cc_q <= {zf, sf, of};
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.valE      = val_e_q;
   assign bus.Cnd       = cnd_q;
   assign bus.out_icode = icode_q;
   assign bus.out_err   = err_q;
   assign bus.cc_out    = cc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe at WIDTH=64: hand-computed expectations
// for reset, ALU paths, condition codes, backpressure and faults.
module tb_execute_pipe;

   localparam int WIDTH = 64;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   execute_pipe_if #(.WIDTH(WIDTH)) bus ();

   execute_pipe #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      bus.in_valid = 1'b1;
      bus.icode    = ic;
      bus.ifun     = fn;
      bus.valA     = a;
      bus.valB     = b;
      bus.valC     = c;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.icode     = 4'h0;
      bus.ifun      = 4'h0;
      bus.valA      = '0;
      bus.valB      = '0;
      bus.valC      = '0;
      bus.set_cc_en = 1'b1;
      bus.out_ready = 1'b1;
      step();
      step();
      reset = 1'b0;

      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_cc", 64'(bus.cc_out), 64'b100);
      check("rst_valE", bus.valE, 64'd0);

      // Signed overflow on add
      offer(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
      step();
      check("add_valid", 64'(bus.out_valid), 64'd1);
      check("add_valE", bus.valE, 64'h8000_0000_0000_0000);
      check("add_cc", 64'(bus.cc_out), 64'b011);
      check("add_icode", 64'(bus.out_icode), 64'h6);
      check("add_err", 64'(bus.out_err), 64'd0);

      // Sub to zero, then jumps that read the freshly updated CC
      offer(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
      step();
      check("sub_valE", bus.valE, 64'd0);
      check("sub_cc", 64'(bus.cc_out), 64'b100);
      offer(4'h7, 4'h3, 64'd0, 64'd0, 64'h40);
      step();
      check("je_cnd", 64'(bus.Cnd), 64'd1);
      offer(4'h7, 4'h4, 64'd0, 64'd0, 64'h40);
      step();
      check("jne_cnd", 64'(bus.Cnd), 64'd0);

      // Stack arithmetic
      offer(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
      step();
      check("push_valE", bus.valE, 64'hF8);
      check("push_cc", 64'(bus.cc_out), 64'b100);
      offer(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
      step();
      check("pop_valE", bus.valE, 64'h108);
      check("pop_cc", 64'(bus.cc_out), 64'b100);
      check("pop_cnd", 64'(bus.Cnd), 64'd0);

      // Backpressure: held result, blocked OPq, CC untouched
      bus.out_ready = 1'b0;
      offer(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      step();
      step();
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_valE", bus.valE, 64'h108);
      check("bp_icode", 64'(bus.out_icode), 64'hB);
      check("bp_cc", 64'(bus.cc_out), 64'b100);
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(bus.in_ready), 64'd1);
      step();
      check("bp_accept_valE", bus.valE, 64'd2);
      check("bp_accept_cc", 64'(bus.cc_out), 64'b000);

      // Suppressed CC write
      bus.set_cc_en = 1'b0;
      offer(4'h6, 4'h1, 64'd2, 64'd1, 64'd0);
      step();
      check("nocc_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFF);
      check("nocc_cc", 64'(bus.cc_out), 64'b000);
      bus.set_cc_en = 1'b1;

      // Illegal icode and illegal OPq function
      offer(4'hC, 4'h0, 64'd7, 64'd9, 64'd3);
      step();
      check("ill_err", 64'(bus.out_err), 64'd1);
      check("ill_valE", bus.valE, 64'd0);
      check("ill_valid", 64'(bus.out_valid), 64'd1);
      check("ill_cc", 64'(bus.cc_out), 64'b000);
      offer(4'h6, 4'h5, 64'd0, 64'd0, 64'd0);
      step();
      check("illop_err", 64'(bus.out_err), 64'd1);
      check("illop_cc", 64'(bus.cc_out), 64'b000);

      // cmovXX: unconditional move passes valA, Cnd=1; cmovl with SF^OF=0 gives 0
      offer(4'h2, 4'h0, 64'h1234, 64'd0, 64'd0);
      step();
      check("rrmov_valE", bus.valE, 64'h1234);
      check("rrmov_cnd", 64'(bus.Cnd), 64'd1);
      check("rrmov_err", 64'(bus.out_err), 64'd0);
      offer(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0);
      step();
      check("cmovl_cnd", 64'(bus.Cnd), 64'd0);

      // irmovq uses valC
      offer(4'h3, 4'h0, 64'd1, 64'd2, 64'hABCD);
      step();
      check("irmov_valE", bus.valE, 64'hABCD);

      // Drain with no new offer
      bus.in_valid = 1'b0;
      step();
      check("drain_valid", 64'(bus.out_valid), 64'd0);

      // Reset while stalled discards the held result and restores CC
      offer(4'h6, 4'h0, 64'd3, 64'd4, 64'd0);
      step();
      check("pre_rst_valE", bus.valE, 64'd7);
      bus.out_ready = 1'b0;
      reset = 1'b1;
      step();
      check("midrst_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_valE", bus.valE, 64'd0);
      check("midrst_cc", 64'(bus.cc_out), 64'b100);
      check("midrst_icode", 64'(bus.out_icode), 64'h0);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data-path width in bits; legal values are multiples of 8 and at least 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  an instruction is offered.
REQ-005 SHALL have port in_ready  output  1  the block can accept an instruction this cycle.
REQ-006 SHALL have ports icode and ifun, each input  4  Y86 instruction code and function code.
REQ-007 SHALL have ports valA, valB and valC, each input  WIDTH  decoded operands.
REQ-008 SHALL have port set_cc_en  input  1  allows CC update; driven low by a downstream exception or bubble.
REQ-009 SHALL have port out_valid  output  1  the result register holds a valid result.
REQ-010 SHALL have port out_ready  input  1  the downstream stage accepts the result.
REQ-011 SHALL have port valE  output  WIDTH  registered ALU result.
REQ-012 SHALL have port Cnd  output  1  registered condition outcome.
REQ-013 SHALL have port out_icode  output  4  registered icode, passed through.
REQ-014 SHALL have port out_err  output  1  registered illegal-icode flag.
REQ-015 SHALL have port cc_out  output  3  current CC register {ZF,SF,OF}.

Function
REQ-016 SHALL accept an instruction when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL, on accept, load valE/Cnd/out_icode/out_err and set out_valid=1 on the next edge; latency is 1 cycle.
REQ-018 SHALL clear out_valid when out_ready=1 and no accept occurs in the same cycle; an accept with out_ready=1 overwrites the register with no bubble.
REQ-019 SHALL hold all registered outputs stable while out_valid=1 and out_ready=0.
REQ-020 SHALL select ALU A: valA for icode 2 and 6; valC for 3, 4 and 5; -(WIDTH/8) for 8 and A; +(WIDTH/8) for 9 and B; 0 otherwise.
REQ-021 SHALL select ALU B: valB for icode 4, 5, 6, 8, 9, A and B; 0 otherwise.
REQ-022 SHALL use ALU function ifun for icode 6 (0 add B+A, 1 sub B-A, 2 and, 3 xor) and add for all other icodes; OPq with ifun>3 SHALL set out_err=1 and leave CC unchanged.
REQ-023 SHALL compute results modulo 2^WIDTH, with no carry output.
REQ-024 SHALL compute flags as ZF=(result==0) and SF=result[WIDTH-1].
REQ-025 SHALL compute OF for add as (A,B same sign) && result sign differs from A.
REQ-026 SHALL compute OF for sub as (A,B sign differ) && result sign differs from B.
REQ-027 SHALL compute OF=0 for and and xor.
REQ-028 SHALL write the CC register only on accept of icode 6 with legal ifun and set_cc_en=1.
REQ-029 SHALL compute Cnd for icode 2 and 7 from the CC value before this instruction's update: ifun 0 gives 1; 1 le gives (SF^OF)|ZF; 2 l gives SF^OF; 3 e gives ZF; 4 ne gives !ZF; 5 ge gives !(SF^OF); 6 g gives !(SF^OF)&&!ZF; 7-F give 0. Cnd SHALL be 0 for all other icodes.
REQ-030 SHALL, for icode greater than B, set out_err=1 and valE=0, leave CC unchanged and still assert out_valid.
REQ-031 SHALL make a CC update from one accepted OPq visible to the very next accepted instruction (back-to-back OPq then jXX).

Reset
REQ-032 SHALL, on reset=1 at a clock edge, set out_valid=0, valE=0, Cnd=0, out_icode=0, out_err=0 and CC={ZF=1,SF=0,OF=0}, overriding any same-cycle accept.
REQ-033 SHALL discard an in-flight result when reset is asserted mid-stall, even if out_ready=0.

Verification (WIDTH=64)
REQ-034 SHALL cover reset: after reset, out_valid=0, in_ready=1 and cc_out=3'b100.
REQ-035 SHALL cover signed overflow on add: OPq ifun0 with valA=0x7FFFFFFFFFFFFFFF and valB=1 -> valE=0x8000000000000000, cc_out=3'b011 one cycle later.
REQ-036 SHALL cover sub then conditional jumps: OPq ifun1 with valA=valB=5 -> valE=0, ZF=1; next jXX ifun3 -> Cnd=1; then jXX ifun4 -> Cnd=0.
REQ-037 SHALL cover stack arithmetic: pushq with valB=0x100 -> valE=0xF8; popq with valB=0x100 -> valE=0x108; CC unchanged in both cases.
REQ-038 SHALL cover backpressure: with out_valid=1 and out_ready=0, in_ready=0; an offered OPq is not accepted, and CC and outputs are held until out_ready=1.
REQ-039 SHALL cover suppressed CC and illegal icode: OPq sub with valA=2, valB=1 and set_cc_en=0 -> valE=0xFFFFFFFFFFFFFFFF, CC unchanged; icode 0xC -> out_err=1, valE=0.
